// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad matrix scanner.
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;

    typedef enum logic [1:0] {KP_IDLE, KP_CONFIRM, KP_PRESSED} kp_state_t;

    typedef enum {FR_NONE, FR_SINGLE, FR_MULTI} kp_frame_t;

    // Classifies a captured frame; idx is the position of the highest set bit,
    // and is only meaningful when the class is FR_SINGLE.
    function automatic kp_frame_t frame_classify(
        input  logic [KP_ROWS*KP_COLS-1:0] frame,
        output logic [3:0]                 idx
    );
        int unsigned n;
        n   = 0;
        idx = '0;
        for (int i = 0; i < KP_ROWS * KP_COLS; i++) begin
            if (frame[i]) begin
                n++;
                idx = 4'(i);
            end
        end
        if (n == 0) begin
            return FR_NONE;
        end else if (n == 1) begin
            return FR_SINGLE;
        end
        return FR_MULTI;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Row-dwell divider: one-cycle tick every F_CLK/F_SCAN clocks.
module keypad_tick_gen #(
    parameter int unsigned F_CLK  = 50000000,
    parameter int unsigned F_SCAN = 1000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned Dwell = F_CLK / F_SCAN;
    localparam int unsigned CntW  = $clog2(Dwell);
    localparam logic [CntW-1:0] LastCnt = CntW'(Dwell - 1);
    localparam logic [CntW-1:0] One     = CntW'(1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + One;
        end
    end

    assign tick = (cnt_q == LastCnt);

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 key matrix scanner: row strobing, frame capture and whole-frame debounce.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned F_CLK          = 50000000,
    parameter int unsigned F_SCAN         = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int unsigned FrameBits = KP_ROWS * KP_COLS;
    localparam logic [3:0]  DebN      = 4'(DEBOUNCE_SCANS);

    logic tick;

    keypad_tick_gen #(
        .F_CLK  (F_CLK),
        .F_SCAN (F_SCAN)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    logic [3:0] col_meta_q, col_sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta_q <= 4'b1111;
            col_sync_q <= 4'b1111;
        end else begin
            col_meta_q <= col_in;
            col_sync_q <= col_meta_q;
        end
    end

    logic [1:0]           row_ptr_q;
    logic [FrameBits-1:0] frame_q, frame_full;
    logic                 frame_done;
    kp_frame_t            frame_cls;
    logic [3:0]           frame_idx;

    // Current frame with the row being sampled on this tick merged in (pressed = 1).
    always_comb begin
        frame_full = frame_q;
        frame_full[{row_ptr_q, 2'b00} +: 4] = ~col_sync_q;
        frame_cls = frame_classify(frame_full, frame_idx);
    end

    assign frame_done = tick && (row_ptr_q == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_ptr_q <= 2'd0;
            row_out   <= 4'b1110;
            frame_q   <= '0;
        end else if (tick) begin
            frame_q   <= frame_full;
            row_ptr_q <= row_ptr_q + 2'd1;
            row_out   <= ~(4'b0001 << (row_ptr_q + 2'd1));
        end
    end

    kp_state_t  state_q;
    logic [3:0] cand_q, cnt_q, rcnt_q;
    logic       hit_single, confirm;
    logic [3:0] next_cnt;

    always_comb begin
        hit_single = (frame_cls == FR_SINGLE);
        next_cnt   = (state_q == KP_CONFIRM && frame_idx == cand_q) ? cnt_q + 4'd1 : 4'd1;
        confirm    = hit_single && (state_q != KP_PRESSED) && (next_cnt >= DebN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= KP_IDLE;
            cand_q    <= 4'd0;
            cnt_q     <= 4'd0;
            rcnt_q    <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (frame_done) begin
                case (state_q)
                    KP_IDLE, KP_CONFIRM: begin
                        if (confirm) begin
                            state_q   <= KP_PRESSED;
                            cand_q    <= frame_idx;
                            cnt_q     <= DebN;
                            rcnt_q    <= 4'd0;
                            key_code  <= frame_idx;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                        end else if (hit_single) begin
                            state_q <= KP_CONFIRM;
                            cand_q  <= frame_idx;
                            cnt_q   <= next_cnt;
                        end else begin
                            state_q <= KP_IDLE;
                            cnt_q   <= 4'd0;
                        end
                    end
                    KP_PRESSED: begin
                        // Any key activity, even a different key, restarts the release count.
                        if (frame_cls == FR_NONE) begin
                            if (rcnt_q + 4'd1 >= DebN) begin
                                state_q  <= KP_IDLE;
                                key_held <= 1'b0;
                                rcnt_q   <= 4'd0;
                                cnt_q    <= 4'd0;
                            end else begin
                                rcnt_q <= rcnt_q + 4'd1;
                            end
                        end else begin
                            rcnt_q <= 4'd0;
                        end
                    end
                    default: state_q <= KP_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench: table-driven scenarios plus random frames against a frame-level model.
module tb_keypad_matrix_scanner;

    localparam int unsigned DS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  col_in, row_out, key_code;
    logic        key_valid, key_held;
    logic [15:0] keys = '0;

    int errors = 0;
    int checks = 0;

    keypad_matrix_scanner #(
        .F_CLK          (16),
        .F_SCAN         (4),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_in    (col_in),
        .row_out   (row_out),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key shorts its column to its row while that row is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row_out[r] && keys[r*4+c]) col_in[c] = 1'b0;
            end
        end
    end

    // Frame-level reference: history of key sets since reset, judged by trailing run length.
    logic [15:0] hist[$];
    logic        m_held = 1'b0;
    logic [3:0]  m_code = 4'd0;
    logic        cur_held = 1'b0;
    logic [3:0]  cur_code = 4'd0;

    task automatic model_frame(input logic [15:0] s, output logic pulse);
        int run;
        hist.push_back(s);
        run = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != s) break;
            run++;
        end
        pulse = 1'b0;
        if (!m_held && $countones(s) == 1 && run >= int'(DS)) begin
            pulse  = 1'b1;
            m_held = 1'b1;
            for (int b = 0; b < 16; b++) if (s[b]) m_code = 4'(b);
        end else if (m_held && s == 16'h0 && run >= int'(DS)) begin
            m_held = 1'b0;
        end
    endtask

    task automatic check(input string name, input int frm, input logic [3:0] act,
                         input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s frame=%0d got=%h expected=%h", name, frm, act, exp);
        end
    endtask

    task automatic run_frame(input int frm, input logic [15:0] k, input logic use_tbl,
                             input logic t_pulse, input logic [3:0] t_code, input logic t_held);
        logic       mp, e_pulse, e_held;
        logic [3:0] e_code;
        keys = k;
        model_frame(k, mp);
        if (use_tbl) begin
            e_pulse = t_pulse; e_code = t_code; e_held = t_held;
        end else begin
            e_pulse = mp; e_code = m_code; e_held = m_held;
        end
        for (int e = 1; e <= 16; e++) begin
            @(posedge clk);
            @(negedge clk);
            check("row_out", frm, row_out, 4'hF ^ (4'h1 << ((e / 4) % 4)));
            if (e < 16) begin
                check("key_valid_idle", frm, {3'b0, key_valid}, 4'h0);
                check("key_held_mid", frm, {3'b0, key_held}, {3'b0, cur_held});
                check("key_code_mid", frm, key_code, cur_code);
            end else begin
                check("key_valid_end", frm, {3'b0, key_valid}, {3'b0, e_pulse});
                check("key_held_end", frm, {3'b0, key_held}, {3'b0, e_held});
                check("key_code_end", frm, key_code, e_code);
            end
        end
        cur_held = e_held;
        cur_code = e_code;
    endtask

    task automatic do_reset(input int pre);
        repeat (pre) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_row_out", -1, row_out, 4'b1110);
        check("rst_key_valid", -1, {3'b0, key_valid}, 4'h0);
        check("rst_key_held", -1, {3'b0, key_held}, 4'h0);
        check("rst_key_code", -1, key_code, 4'h0);
        repeat (2) begin
            @(posedge clk);
            #1 check("rst_hold_valid", -1, {3'b0, key_valid}, 4'h0);
            check("rst_hold_held", -1, {3'b0, key_held}, 4'h0);
        end
        @(negedge clk) rst = 1'b0;
        hist.delete();
        m_held   = 1'b0;
        m_code   = 4'd0;
        cur_held = 1'b0;
        cur_code = 4'd0;
    endtask

    typedef struct {
        logic [15:0] keys;
        logic        pulse;
        logic [3:0]  code;
        logic        held;
    } vec_t;

    vec_t tbl[27];

    initial begin
        logic [15:0] prev, k;
        int          r;

        tbl[0]  = '{16'h0200, 1'b0, 4'd0,  1'b0};  // key 9 pressed
        tbl[1]  = '{16'h0200, 1'b1, 4'd9,  1'b1};
        tbl[2]  = '{16'h0200, 1'b0, 4'd9,  1'b1};
        tbl[3]  = '{16'h0000, 1'b0, 4'd9,  1'b1};
        tbl[4]  = '{16'h0000, 1'b0, 4'd9,  1'b0};
        tbl[5]  = '{16'h0008, 1'b0, 4'd9,  1'b0};  // key 3 bounce
        tbl[6]  = '{16'h0000, 1'b0, 4'd9,  1'b0};
        tbl[7]  = '{16'h0000, 1'b0, 4'd9,  1'b0};
        tbl[8]  = '{16'h8001, 1'b0, 4'd9,  1'b0};  // keys 0 and 15
        tbl[9]  = '{16'h8001, 1'b0, 4'd9,  1'b0};
        tbl[10] = '{16'h8001, 1'b0, 4'd9,  1'b0};
        tbl[11] = '{16'h0001, 1'b0, 4'd9,  1'b0};
        tbl[12] = '{16'h0001, 1'b1, 4'd0,  1'b1};
        tbl[13] = '{16'h0000, 1'b0, 4'd0,  1'b1};
        tbl[14] = '{16'h0000, 1'b0, 4'd0,  1'b0};
        tbl[15] = '{16'h0020, 1'b0, 4'd0,  1'b0};  // rollover 5 -> 6
        tbl[16] = '{16'h0020, 1'b1, 4'd5,  1'b1};
        tbl[17] = '{16'h0060, 1'b0, 4'd5,  1'b1};
        tbl[18] = '{16'h0040, 1'b0, 4'd5,  1'b1};
        tbl[19] = '{16'h0000, 1'b0, 4'd5,  1'b1};
        tbl[20] = '{16'h0000, 1'b0, 4'd5,  1'b0};
        tbl[21] = '{16'h0040, 1'b0, 4'd5,  1'b0};
        tbl[22] = '{16'h0040, 1'b1, 4'd6,  1'b1};
        tbl[23] = '{16'h0000, 1'b0, 4'd6,  1'b1};
        tbl[24] = '{16'h0000, 1'b0, 4'd6,  1'b0};
        tbl[25] = '{16'h1000, 1'b0, 4'd6,  1'b0};  // key 12 for reset-in-pressed
        tbl[26] = '{16'h1000, 1'b1, 4'd12, 1'b1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        do_reset(2);

        for (int i = 0; i < 27; i++) begin
            run_frame(i, tbl[i].keys, 1'b1, tbl[i].pulse, tbl[i].code, tbl[i].held);
        end

        // Reset while key 12 is held, key stays down through and after reset.
        do_reset(5);
        run_frame(100, 16'h1000, 1'b1, 1'b0, 4'd0, 1'b0);
        run_frame(101, 16'h1000, 1'b1, 1'b1, 4'd12, 1'b1);

        prev = 16'h1000;
        for (int f = 0; f < 60; f++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3) begin
                k = 16'h0000;
            end else if (r < 6) begin
                k = prev;
            end else if (r < 9) begin
                k = 16'h0001 << $urandom_range(0, 15);
            end else begin
                k = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            end
            run_frame(200 + f, k, 1'b0, 1'b0, 4'd0, 1'b0);
            prev = k;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Reads a 4x4 passive key matrix. It drives one row low at a time, senses the four column lines, and debounces at whole-frame granularity. It reports each debounced press as a one-cycle key_valid pulse with a 4-bit key code. It is the sensing-side counterpart to the multiplexed 7-segment scan path, and it feeds the counter/display logic in place of discrete debounced push-buttons.

Parameters:
F_CLK, 50000000, system clock frequency in Hz
F_SCAN, 1000, row-step rate in Hz; row dwell = F_CLK/F_SCAN cycles (integer, >= 4)
DEBOUNCE_SCANS, 4, consecutive identical frames required to confirm a press or a release (1..15)

Ports:
clk  input  1  system clock; all flops on posedge
rst  input  1  asynchronous reset, active-high
col_in  input  4  column sense lines, active-low (pulled up externally), asynchronous to clk
row_out  output  4  row drive, active-low, exactly one bit low at any time
key_code  output  4  code of the last confirmed key = row*4 + col
key_valid  output  1  one-cycle pulse when a press is confirmed; key_code is valid in the same cycle
key_held  output  1  high from the confirm cycle until the release is confirmed

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: row_out=4'b1110, key_code=0, key_valid=0, key_held=0, row pointer=0, FSM=IDLE, frame and debounce counters=0.
- Reset assertion forces these values immediately. No key_valid pulse is emitted for any press in progress when reset asserts.
- col_in passes through a 2-flop synchronizer before use. Synchronizer flops also reset to 4'b1111.
- Tick generator: counter 0..F_CLK/F_SCAN-1. It produces a one-cycle tick at the terminal count, then wraps to 0.
- On each tick:
  - The synchronized columns for the current row are captured into bits [row*4 +: 4] of a 16-bit frame, with a pressed key stored as 1.
  - In the same clock edge the row pointer advances 0->1->2->3->0, and row_out updates to ~(1<<pointer).
  - Sampling therefore happens at the end of each row's dwell, after settling.
- A frame completes on the tick that captures row 3. Frame classification:
  - NONE: all 16 bits are 0.
  - SINGLE(k): exactly one bit k is set.
  - MULTI: two or more bits are set.
- FSM, evaluated only on frame completion:
  - IDLE: on SINGLE(k), set cand=k, cnt=1, and go to CONFIRM. On NONE or MULTI, stay in IDLE.
  - CONFIRM, on SINGLE(cand): cnt++. When cnt reaches DEBOUNCE_SCANS, go to PRESSED. In that cycle key_code=cand, key_valid=1 for one clk, and key_held=1. With DEBOUNCE_SCANS=1, the confirm happens on the first frame.
  - CONFIRM, on SINGLE(other k): restart with cand=k, cnt=1.
  - CONFIRM, on NONE or MULTI: go to IDLE, cnt=0.
  - PRESSED, on NONE: rcnt++. When rcnt reaches DEBOUNCE_SCANS, go to IDLE and set key_held=0.
  - PRESSED, on SINGLE or MULTI (any key, including a different key): rcnt=0 and stay in PRESSED. No new pulse is emitted; a new key needs a full release first.
- key_code holds its value after release until the next confirm.
- Latency:
  - Press: confirm occurs on the DEBOUNCE_SCANS-th complete frame that contains the key. Worst case is (DEBOUNCE_SCANS+1) frames after the key closes.
  - Release: the same bound applies.
- Counters saturate and never wrap: cnt and rcnt are 4 bits and are capped at DEBOUNCE_SCANS.

Decomposition:
- Package keypad_pkg holds:
  - constants KP_ROWS=4 and KP_COLS=4
  - typedef enum logic [1:0] {KP_IDLE, KP_CONFIRM, KP_PRESSED} kp_state_t
  - typedef enum {FR_NONE, FR_SINGLE, FR_MULTI} kp_frame_t
  - function frame_classify(logic [15:0]) returning class and index
- One sub-module: keypad_tick_gen, parameterised by F_CLK and F_SCAN, with ports clk, rst, tick. It is the single-pulse divider.
- The top level contains the synchronizer, row driver, frame capture and FSM.

Test Plan:
Bench uses F_CLK=16, F_SCAN=4 (dwell 4 cycles, frame 16 cycles), DEBOUNCE_SCANS=2. The matrix model pulls col c low while row r is low and key r*4+c is pressed.
- Reset: assert rst mid-dwell -> row_out=4'b1110, key_valid=0, key_held=0 immediately. After release, row_out steps 1101, 1011, 0111, 1110 every 4 cycles.
- Single press of key 9 (row2/col1), held -> exactly one key_valid pulse with key_code=9 at the end of the 2nd full frame. key_held stays 1 until 2 empty frames after release, then drops to 0.
- Bounce: key 3 present for 1 frame, then absent -> no key_valid, key_held stays 0, FSM back in IDLE.
- Multi from idle: keys 0 and 15 pressed together for 3 frames -> no pulse. Then release 15 -> key_valid with key_code=0 after 2 further frames.
- Rollover: hold 5 (confirmed), add 6, release 5 while 6 is held -> no second pulse. Release all for 2 frames -> key_held=0. Press 6 -> new pulse with key_code=6.
- Reset in PRESSED: key 12 confirmed, assert rst for 2 cycles -> key_held=0 at once. With the key held through reset, re-confirm after 2 frames gives key_valid with key_code=12. No pulse occurs during reset.
